ext_bus_timer_slave: RTL

Memory-mapped timer/compare peripheral on the external bus, directly downstream of the MMU's external bus interface. It consumes the enable/write/size/address/data transfer on the bus, answers with a ready pulse after programmable wait states, and supplies read data. It also drives the external interrupt line into the MMU, which the MMU acknowledges back. It gives the core a real wait-stated slave and an interrupt source on the same bus.

---
 rtl/ext_bus_timer_slave.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ext_bus_timer_slave.sv
// ext_bus_timer_slave
//
// Memory-mapped timer/compare peripheral on the external bus. It accepts one
// enable/write/size/address/data transfer at a time and completes it with a
// one-cycle ready pulse after WAIT_STATES wait cycles. It also drives a level
// interrupt (IE & MATCH), which the MMU clears with an acknowledge pulse.
//
// Register map (word offset addr[3:2] inside the 16-byte window at BASE_ADDR):
//   0x0 CTRL    [0] EN, [1] IE, [2] AUTO_RELOAD, [31:16] PRESCALE
//   0x4 COUNT
//   0x8 COMPARE
//   0xC STATUS  [0] MATCH, [1] OVF (write-1-to-clear)
//
// Ports:
//   clk         in   single clock, rising edge
//   reset       in   asynchronous, active-high
//   bus_en_i    in   transfer request, held until bus_rdy_o is seen
//   bus_we_i    in   1 = write, 0 = read
//   bus_size_i  in   00 byte, 01 half, 10/11 word
//   bus_addr_i  in   byte address
//   bus_data_i  in   right-justified write data
//   bus_data_o  out  right-justified read data, 0 unless bus_rdy_o
//   bus_rdy_o   out  one-cycle transfer-complete pulse
//   intr_o      out  level interrupt to the MMU
//   intr_ack_i  in   interrupt acknowledge pulse
//
// The register layout assumes DATA_WIDTH = 32.

module ext_bus_timer_slave #(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 16'hF000,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  bus_en_i,
    input  logic                  bus_we_i,
    input  logic [1:0]            bus_size_i,
    input  logic [ADDR_WIDTH-1:0] bus_addr_i,
    input  logic [DATA_WIDTH-1:0] bus_data_i,
    output logic [DATA_WIDTH-1:0] bus_data_o,
    output logic                  bus_rdy_o,
    output logic                  intr_o,
    input  logic                  intr_ack_i
);

    typedef enum logic [1:0] {StIdle, StWait, StAck, StHold} state_e;

    localparam logic [DATA_WIDTH-1:0] CtrlMask = 32'hFFFF_0007;

    state_e                  state_q, state_d;
    logic [3:0]              wait_cnt_q, wait_cnt_d;
    logic                    latch_req;

    logic                    req_we_q;
    logic [1:0]              req_size_q;
    logic [ADDR_WIDTH-1:0]   req_addr_q;
    logic [DATA_WIDTH-1:0]   req_data_q;

    logic [DATA_WIDTH-1:0]   ctrl_q, ctrl_d;
    logic [DATA_WIDTH-1:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0]   compare_q, compare_d;
    logic                    match_q, match_d;
    logic                    ovf_q, ovf_d;
    logic [15:0]             pre_q, pre_d;

    // ------------------------------------------------------------------
    // Bus FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        latch_req  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus_en_i) begin
                    latch_req  = 1'b1;
                    wait_cnt_d = WAIT_STATES[3:0];
                    state_d    = (WAIT_STATES == 0) ? StAck : StWait;
                end
            end
            StWait: begin
                // One WAIT cycle per wait state; the <= guards a zero count.
                if (wait_cnt_q <= 4'd1) begin
                    state_d = StAck;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            StAck: begin
                state_d = StHold;
            end
            StHold: begin
                // Wait for the master to release the enable so a held
                // request is never serviced twice.
                if (!bus_en_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            wait_cnt_q <= 4'd0;
            req_we_q   <= 1'b0;
            req_size_q <= 2'b00;
            req_addr_q <= '0;
            req_data_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (latch_req) begin
                req_we_q   <= bus_we_i;
                req_size_q <= bus_size_i;
                req_addr_q <= bus_addr_i;
                req_data_q <= bus_data_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Decode and lane alignment of the latched request
    // ------------------------------------------------------------------
    logic                  ack;
    logic                  in_window;
    logic [1:0]            reg_sel;
    logic [1:0]            lane;
    logic                  wr_fire;
    logic                  wr_ctrl, wr_count, wr_compare, wr_status;
    logic [DATA_WIDTH-1:0] wmask;
    logic [DATA_WIDTH-1:0] wdata_al;
    logic [DATA_WIDTH-1:0] rd_word;

    assign ack       = (state_q == StAck);
    assign in_window = (req_addr_q[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]);
    assign reg_sel   = req_addr_q[3:2];
    assign lane      = req_addr_q[1:0];
    assign wr_fire   = ack && req_we_q && in_window;

    assign wr_ctrl    = wr_fire && (reg_sel == 2'd0);
    assign wr_count   = wr_fire && (reg_sel == 2'd1);
    assign wr_compare = wr_fire && (reg_sel == 2'd2);
    assign wr_status  = wr_fire && (reg_sel == 2'd3);

    // Place the right-justified write data into its byte lanes; wmask marks
    // which lanes the transfer actually touches.
    always_comb begin
        wmask    = '0;
        wdata_al = '0;
        case (req_size_q)
            2'b00: begin
                wmask    = 32'h0000_00FF << {lane, 3'b000};
                wdata_al = {24'h0, req_data_q[7:0]} << {lane, 3'b000};
            end
            2'b01: begin
                if (lane[1]) begin
                    wmask    = 32'hFFFF_0000;
                    wdata_al = {req_data_q[15:0], 16'h0};
                end else begin
                    wmask    = 32'h0000_FFFF;
                    wdata_al = {16'h0, req_data_q[15:0]};
                end
            end
            default: begin
                wmask    = '1;
                wdata_al = req_data_q;
            end
        endcase
    end

    function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old,
                                                    input logic [DATA_WIDTH-1:0] data,
                                                    input logic [DATA_WIDTH-1:0] mask);
        return (old & ~mask) | (data & mask);
    endfunction

    always_comb begin
        rd_word = '0;
        case (reg_sel)
            2'd0:    rd_word = ctrl_q;
            2'd1:    rd_word = count_q;
            2'd2:    rd_word = compare_q;
            default: rd_word = {30'h0, ovf_q, match_q};
        endcase
    end

    assign bus_rdy_o  = ack;
    assign bus_data_o = (ack && !req_we_q && in_window) ? (rd_word >> {lane, 3'b000}) : '0;

    // ------------------------------------------------------------------
    // Timer
    // ------------------------------------------------------------------
    logic        ctrl_en;
    logic        ctrl_ie;
    logic        ctrl_auto;
    logic [15:0] prescale;
    logic        tick;
    logic        set_match, set_ovf;
    logic [1:0]  w1c;

    assign ctrl_en   = ctrl_q[0];
    assign ctrl_ie   = ctrl_q[1];
    assign ctrl_auto = ctrl_q[2];
    assign prescale  = ctrl_q[31:16];
    assign tick      = ctrl_en && (pre_q == prescale);

    assign set_match = tick && (count_q == compare_q);
    assign set_ovf   = tick && (count_q == '1);
    assign w1c       = wr_status ? (wdata_al[1:0] & wmask[1:0]) : 2'b00;

    always_comb begin
        ctrl_d    = wr_ctrl ? (merge(ctrl_q, wdata_al, wmask) & CtrlMask) : ctrl_q;
        compare_d = wr_compare ? merge(compare_q, wdata_al, wmask) : compare_q;

        pre_d = pre_q;
        if (wr_ctrl) begin
            pre_d = '0;
        end else if (ctrl_en) begin
            pre_d = tick ? 16'd0 : pre_q + 16'd1;
        end

        // A bus write wins over the tick; all-ones wraps to 0 via the +1.
        count_d = count_q;
        if (wr_count) begin
            count_d = merge(count_q, wdata_al, wmask);
        end else if (tick) begin
            count_d = (set_match && ctrl_auto) ? '0 : count_q + 32'd1;
        end

        // Setting a flag wins over clearing it in the same cycle.
        match_d = set_match | (match_q & ~(w1c[0] | intr_ack_i));
        ovf_d   = set_ovf   | (ovf_q   & ~w1c[1]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q    <= '0;
            count_q   <= '0;
            compare_q <= '0;
            match_q   <= 1'b0;
            ovf_q     <= 1'b0;
            pre_q     <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            match_q   <= match_d;
            ovf_q     <= ovf_d;
            pre_q     <= pre_d;
        end
    end

    assign intr_o = ctrl_ie & match_q;

endmodule
